in256_out1536_pack: RTL

Upstream width packer for the 1536-bit flexible down-converter. Gathers 1 to 6 consecutive 256-bit AXI-Stream beats into one 1536-bit word, first beat in the least-significant lane, and zero-fills unused lanes. Uses an assembly buffer plus an output register, so it sustains one input beat per cycle while the consumer keeps m_axis_tready high.

---
 rtl/in256_out1536_pack_if.sv | 28 ++
 rtl/in256_out1536_pack.sv | 114 +++++++++++
 2 files changed

// File: rtl/in256_out1536_pack_if.sv
// Stream bundle for the 256->1536 packer: the upstream beat stream, the packed
// word stream and the per-word beat count.
interface in256_out1536_pack_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 1536
);
  logic [2:0]           pack_num;
  logic [IN_WIDTH-1:0]  s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;

  // Packer side.
  modport slave (
    input  pack_num, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Producer/consumer side.
  modport master (
    output pack_num, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/in256_out1536_pack.sv
// Packs 1..RATIO consecutive IN_WIDTH beats into one OUT_WIDTH word, first beat
// in lane 0, unused lanes zero. Assembly buffer + output register per lane.
module in256_out1536_pack_lane #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         wr,
  input  logic         asm_clr,
  input  logic         out_ld,
  output logic [W-1:0] out_q
);
  logic [W-1:0] asm_q;

  // The output load sees the incoming beat when this lane is written in the
  // same cycle, so a completing beat goes straight to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      out_q <= '0;
    end else begin
      if (asm_clr)  asm_q <= '0;
      else if (wr)  asm_q <= din;
      if (out_ld)   out_q <= wr ? din : asm_q;
    end
  end
endmodule

module in256_out1536_pack #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 1536,
  parameter int RATIO     = 6
) (
  input  logic clk,
  input  logic rst,
  in256_out1536_pack_if.slave bus
);
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [2:0] RATIO_P = 3'(RATIO);

  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] cnt, num_q, num_eff, pn_clamp;
  logic             last_q, m_valid_q, m_last_q;
  logic             asm_full, accept, complete, out_free, out_ld;
  logic [RATIO-1:0] wr;
  logic [RATIO-1:0][IN_WIDTH-1:0] out_lanes;

  assign asm_full = (state == HOLD);
  assign bus.s_axis_tready = !asm_full && !rst;
  assign accept   = bus.s_axis_tvalid && !asm_full && !rst;
  assign out_free = !m_valid_q || bus.m_axis_tready;

  always_comb begin
    pn_clamp = CNT_W'((bus.pack_num == 3'd0 || bus.pack_num > RATIO_P) ? RATIO_P : bus.pack_num);
    num_eff  = (cnt == '0) ? pn_clamp : num_q;
  end

  assign complete = accept && ((cnt == num_eff - CNT_W'(1)) || bus.s_axis_tlast);
  // Drain of a held word and direct load of a fresh word are exclusive:
  // no beat is accepted while the assembly buffer is full.
  assign out_ld   = out_free && (asm_full || complete);

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (complete && !out_free) state_nx = HOLD;
      HOLD:    if (out_free)              state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      num_q     <= CNT_W'(RATIO);
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (complete)    cnt <= '0;
      else if (accept) cnt <= cnt + CNT_W'(1);
      if (accept && cnt == '0) num_q <= pn_clamp;
      if (complete && !out_free) last_q <= bus.s_axis_tlast;
      if (out_ld) begin
        m_valid_q <= 1'b1;
        m_last_q  <= asm_full ? last_q : bus.s_axis_tlast;
      end else if (bus.m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign wr[i] = accept && (cnt == CNT_W'(i));
    in256_out1536_pack_lane #(.W(IN_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .din     (bus.s_axis_tdata),
      .wr      (wr[i]),
      .asm_clr (out_ld),
      .out_ld  (out_ld),
      .out_q   (out_lanes[i])
    );
  end

  assign bus.m_axis_tdata  = out_lanes;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tlast  = m_last_q;
endmodule
